// File: rtl/dc_preload_engine_pkg.sv
// Shared data-cache preload types and sizes.
// Bank/row geometry and the preload FSM states.
package gpgpu_dc_pkg;

  localparam int DC_BANKS       = 8;
  localparam int DC_DEPTH       = 512;
  localparam int DC_DATA_W      = 32;
  localparam int DC_TOTAL_WORDS = DC_BANKS * DC_DEPTH;

  localparam int DC_BANK_W = 3;
  localparam int DC_ROW_W  = 9;
  localparam int DC_IDX_W  = 12;
  localparam int DC_CNT_W  = 13;

  typedef logic [DC_IDX_W-1:0] dc_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FILL,
    DONE
  } dc_state_e;

endpackage

// File: rtl/dc_preload_engine_if.sv
// Word-stream input and bank write port bundle.
// master = source/cache side, slave = preload engine.
interface dc_preload_if;
  import gpgpu_dc_pkg::*;

  logic                 in_valid;
  logic [DC_DATA_W-1:0] in_data;
  logic                 in_last;
  logic                 in_ready;
  logic [DC_BANKS-1:0]  dc_we;
  logic [DC_ROW_W-1:0]  dc_addr;
  logic [DC_DATA_W-1:0] dc_wdata;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready,
    input  dc_we,
    input  dc_addr,
    input  dc_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready,
    output dc_we,
    output dc_addr,
    output dc_wdata
  );

endinterface

// File: rtl/dc_preload_engine_addr_gen.sv
// Word index counter for the cache image.
// Splits idx into one-hot bank and row; flags last word.
module dc_bank_addr_gen
  import gpgpu_dc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [DC_BANKS-1:0] bank_oh_o,
  output logic [DC_ROW_W-1:0] row_o,
  output logic                tc_o
);

  localparam dc_idx_t LAST_IDX =
    dc_idx_t'(DC_TOTAL_WORDS - 1);

  dc_idx_t idx_q;
  dc_idx_t idx_d;

  // clear wins over increment; wraps harmlessly past the end
  always_comb begin
    idx_d = idx_q;
    if (clr_i)
      idx_d = '0;
    else if (inc_i)
      idx_d = idx_q + dc_idx_t'(1);
  end

  // word index register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idx_q <= '0;
    else
      idx_q <= idx_d;
  end

  // bank = low bits, row = high bits
  always_comb begin
    bank_oh_o = DC_BANKS'(1) << idx_q[DC_BANK_W-1:0];
    row_o     = idx_q[DC_IDX_W-1:DC_BANK_W];
    tc_o      = (idx_q == LAST_IDX);
  end

endmodule

// File: rtl/dc_preload_engine.sv
// Fills the eight data-cache banks from a word stream.
// Holds the warp scheduler until the image is written.
module dc_preload_engine
  import gpgpu_dc_pkg::*;
#(
  parameter int ZERO_FILL = 1
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  dc_preload_if.slave          bus,
  output logic                 busy,
  output logic                 done,
  output logic                 gpu_hold,
  output logic [DC_DATA_W-1:0] checksum,
  output logic [DC_CNT_W-1:0]  words_rx
);

  dc_state_e state_q;
  dc_state_e state_d;

  logic                 in_ready_w;
  logic                 hs;
  logic                 clr;
  logic                 inc;
  logic [DC_BANKS-1:0]  bank_oh;
  logic [DC_ROW_W-1:0]  row;
  logic                 tc;

  logic [DC_BANKS-1:0]  we_q;
  logic [DC_BANKS-1:0]  we_d;
  logic [DC_ROW_W-1:0]  addr_q;
  logic [DC_ROW_W-1:0]  addr_d;
  logic [DC_DATA_W-1:0] wdata_q;
  logic [DC_DATA_W-1:0] wdata_d;
  logic [DC_DATA_W-1:0] csum_q;
  logic [DC_DATA_W-1:0] csum_d;
  logic [DC_CNT_W-1:0]  cnt_q;
  logic [DC_CNT_W-1:0]  cnt_d;

  assign in_ready_w = (state_q == LOAD);
  assign hs  = bus.in_valid && in_ready_w;
  assign clr = start &&
               ((state_q == IDLE) || (state_q == DONE));
  assign inc = hs || (state_q == FILL);

  dc_bank_addr_gen u_addr (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr),
    .inc_i     (inc),
    .bank_oh_o (bank_oh),
    .row_o     (row),
    .tc_o      (tc)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // FSM next state: last slot always ends the load
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (hs) begin
          if (tc)
            state_d = DONE;
          else if (bus.in_last)
            state_d = (ZERO_FILL != 0) ? FILL : DONE;
        end
      end
      FILL: if (tc) state_d = DONE;
      DONE: if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // write port, checksum and word count next values
  always_comb begin
    we_d    = '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    csum_d  = csum_q;
    cnt_d   = cnt_q;
    if (clr) begin
      csum_d = '0;
      cnt_d  = '0;
    end
    if (hs) begin
      we_d    = bank_oh;
      addr_d  = row;
      wdata_d = bus.in_data;
      csum_d  = csum_q ^ bus.in_data;
      cnt_d   = cnt_q + DC_CNT_W'(1);
    end else if (state_q == FILL) begin
      we_d    = bank_oh;
      addr_d  = row;
      wdata_d = '0;
    end
  end

  // one-cycle write pipeline and running totals
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      csum_q  <= '0;
      cnt_q   <= '0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM outputs; done waits for the final write to drain
  always_comb begin
    bus.in_ready = in_ready_w;
    bus.dc_we    = we_q;
    bus.dc_addr  = addr_q;
    bus.dc_wdata = wdata_q;
    busy     = (state_q == LOAD) || (state_q == FILL);
    done     = (state_q == DONE) && (we_q == '0);
    gpu_hold = !done;
    checksum = csum_q;
    words_rx = cnt_q;
  end

endmodule

// File: tb/tb_dc_preload_engine.sv
// Directed bench for the data-cache preload engine.
// Rebuilds the bank image from observed writes.
module tb_dc_preload_engine;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic        busy;
  logic        done;
  logic        gpu_hold;
  logic [31:0] checksum;
  logic [12:0] words_rx;

  dc_preload_if bus ();

  dc_preload_engine #(.ZERO_FILL(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .gpu_hold (gpu_hold),
    .checksum (checksum),
    .words_rx (words_rx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:511][0:7];
  int cyc = 0;
  int last_wr = 0;
  int done_cyc = 0;
  int fill_cnt = 0;
  int wr_cnt = 0;
  int bad_we = 0;
  bit hs_prev = 0;
  bit fill_prev = 0;
  bit done_prev = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // capture writes and confirm each follows a handshake or fill slot
  always @(negedge clk) begin
    if (rst) begin
      hs_prev   = 0;
      fill_prev = 0;
      done_prev = 0;
    end else begin
      if ((bus.dc_we != 0) != (hs_prev || fill_prev))
        bad_we++;
      if ((bus.dc_we & (bus.dc_we - 8'd1)) != 0)
        bad_we++;
      if (bus.dc_we != 0) begin
        wr_cnt++;
        last_wr = cyc;
        for (int b = 0; b < 8; b++)
          if (bus.dc_we[b])
            mem[bus.dc_addr][b] = bus.dc_wdata;
      end
      if (done && !done_prev) done_cyc = cyc;
      done_prev = done;
      if (busy && !bus.in_ready) fill_cnt++;
      hs_prev   = bus.in_valid && bus.in_ready;
      fill_prev = busy && !bus.in_ready;
    end
  end

  function automatic logic [31:0] dat(input int pat,
                                      input int k);
    logic [31:0] kk;
    kk = k;
    case (pat)
      1:       return 32'hA5A5_0000 + kk;
      2:       return kk * 32'h9E37_79B1;
      default: return kk;
    endcase
  endfunction

  function automatic logic [31:0] csum(input int n,
                                       input int pat);
    logic [31:0] x;
    x = 0;
    for (int k = 0; k < n; k++) x ^= dat(pat, k);
    return x;
  endfunction

  function automatic int img_err(input int n,
                                 input int pat);
    int e;
    logic [31:0] exp;
    e = 0;
    for (int k = 0; k < 4096; k++) begin
      exp = (k < n) ? dat(pat, k) : 32'h0;
      if (mem[k/8][k%8] !== exp) e++;
    end
    return e;
  endfunction

  task automatic clear_mem();
    for (int r = 0; r < 512; r++)
      for (int b = 0; b < 8; b++)
        mem[r][b] = 32'hDEAD_BEEF;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic stream(input int n, input int last_k,
                        input int pat, input bit tog,
                        input int start_at);
    int k;
    int t;
    bit hs;
    k = 0;
    t = 0;
    while (k < n && t < 20000) begin
      bus.in_valid = tog ? (t % 2 == 0) : 1'b1;
      bus.in_data  = dat(pat, k);
      bus.in_last  = (k == last_k);
      start = (k == start_at);
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      start = 0;
      if (hs) k++;
      t++;
    end
    bus.in_valid = 0;
    bus.in_last  = 0;
    check("stream_words", k, n);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    @(posedge clk); #1;
    check(tag, {31'b0, done}, 1);
  endtask

  int f0, w0, b0;

  initial begin
    bus.in_valid = 0;
    bus.in_data  = 0;
    bus.in_last  = 0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_hold", {31'b0, gpu_hold}, 1);
    check("rst_ready", {31'b0, bus.in_ready}, 0);
    check("rst_we", {24'b0, bus.dc_we}, 0);
    check("rst_addr", {23'b0, bus.dc_addr}, 0);
    check("rst_wdata", bus.dc_wdata, 0);
    check("rst_csum", checksum, 0);
    check("rst_rx", {19'b0, words_rx}, 0);

    // 1: full load, no gaps
    f0 = fill_cnt; b0 = bad_we;
    do_start();
    check("s1_busy", {31'b0, busy}, 1);
    stream(4096, -1, 0, 0, -1);
    wait_done("s1_done");
    check("s1_img", img_err(4096, 0), 0);
    check("s1_b5r1", mem[1][5], 13);
    check("s1_rx", {19'b0, words_rx}, 4096);
    check("s1_csum", checksum, csum(4096, 0));
    check("s1_hold", {31'b0, gpu_hold}, 0);
    check("s1_done_lat", done_cyc - last_wr, 1);
    check("s1_fill", fill_cnt - f0, 0);
    check("s1_we", bad_we - b0, 0);

    // 2: backpressure, restart from DONE
    clear_mem();
    f0 = fill_cnt; b0 = bad_we; w0 = wr_cnt;
    do_start();
    check("s2_hold", {31'b0, gpu_hold}, 1);
    stream(4096, -1, 0, 1, -1);
    wait_done("s2_done");
    check("s2_img", img_err(4096, 0), 0);
    check("s2_csum", checksum, csum(4096, 0));
    check("s2_we", bad_we - b0, 0);
    check("s2_wr", wr_cnt - w0, 4096);

    // 3: early last, zero fill
    clear_mem();
    f0 = fill_cnt; b0 = bad_we;
    do_start();
    stream(20, 19, 1, 0, -1);
    wait_done("s3_done");
    check("s3_img", img_err(20, 1), 0);
    check("s3_r2b3", mem[2][3], 32'hA5A5_0013);
    check("s3_fill", fill_cnt - f0, 4076);
    check("s3_rx", {19'b0, words_rx}, 20);
    check("s3_csum", checksum, csum(20, 1));
    check("s3_we", bad_we - b0, 0);

    // 4a: last on final word
    clear_mem();
    f0 = fill_cnt;
    do_start();
    stream(4096, 4095, 2, 0, -1);
    wait_done("s4a_done");
    check("s4a_fill", fill_cnt - f0, 0);
    check("s4a_img", img_err(4096, 2), 0);
    check("s4a_csum", checksum, csum(4096, 2));
    check("s4a_lat", done_cyc - last_wr, 1);

    // 4b: no last at all
    clear_mem();
    f0 = fill_cnt;
    do_start();
    stream(4096, -1, 0, 0, -1);
    wait_done("s4b_done");
    check("s4b_fill", fill_cnt - f0, 0);
    check("s4b_img", img_err(4096, 0), 0);

    // 5: start while busy is ignored
    clear_mem();
    do_start();
    stream(4096, -1, 0, 0, 100);
    wait_done("s5_done");
    check("s5_rx", {19'b0, words_rx}, 4096);
    check("s5_img", img_err(4096, 0), 0);

    // 6: reset mid-load, then reload
    do_start();
    stream(300, -1, 0, 0, -1);
    rst = 1;
    #1;
    check("s6_busy", {31'b0, busy}, 0);
    check("s6_done", {31'b0, done}, 0);
    check("s6_hold", {31'b0, gpu_hold}, 1);
    check("s6_rx", {19'b0, words_rx}, 0);
    check("s6_we", {24'b0, bus.dc_we}, 0);
    @(posedge clk); #1 rst = 0;
    clear_mem();
    b0 = bad_we;
    do_start();
    stream(4096, -1, 0, 0, -1);
    wait_done("s6r_done");
    check("s6r_img", img_err(4096, 0), 0);
    check("s6r_rx", {19'b0, words_rx}, 4096);
    check("s6r_we", bad_we - b0, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
